// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: debounces start/stop and lap buttons and sequences the counter.
// Optional STOPWATCH_AUTO_STOP_EN: a terminal-count pulse in RUN pauses the stopwatch.
module stopwatch_ctrl #(
  parameter int unsigned CW          = 7,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned LONG_CYCLES = 200000000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          btn_ss,
  input  logic          btn_lap,
  input  logic [CW-1:0] count_in,
  input  logic          cnt_tc,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic [CW-1:0] disp_value,
  output logic          lap_active,
  output logic [1:0]    state_o
);

  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned LG_W = $clog2(LONG_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  // Index 0 = start/stop, index 1 = lap
  logic [1:0]      sync1_q, sync2_q, stable_q, stable_d, rise_c, fall_c;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic [LG_W-1:0] hold_q, hold_d;
  logic            long_fired_q, long_fired_d;
  logic            long_c, short_c, lap_c;

  state_e          state_q, state_d;
  logic            cnt_en_q, cnt_en_d;
  logic            cnt_clr_q, cnt_clr_d;
  logic            lap_act_q, lap_act_d;
  logic [CW-1:0]   lap_q, lap_d;
  logic [CW-1:0]   disp_q, disp_d;

  // Debounce: a level is accepted after it differs from the stable level for DB_CYCLES cycles
  always_comb begin
    stable_d = stable_q;
    rise_c   = '0;
    fall_c   = '0;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
          rise_c[i]   = sync2_q[i];
          fall_c[i]   = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Press classification: long fires once at the hold threshold and suppresses the release short
  always_comb begin
    hold_d = '0;
    if (stable_q[0]) begin
      hold_d = (hold_q == LG_W'(LONG_CYCLES - 1)) ? hold_q : hold_q + LG_W'(1);
    end
    long_c       = stable_q[0] && (hold_q == LG_W'(LONG_CYCLES - 2));
    short_c      = fall_c[0] && !long_fired_q && !long_c;
    lap_c        = rise_c[1];
    long_fired_d = long_fired_q;
    if (rise_c[0]) long_fired_d = 1'b0;
    else if (long_c) long_fired_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      db_cnt_q[0]  <= '0;
      db_cnt_q[1]  <= '0;
      hold_q       <= '0;
      long_fired_q <= 1'b0;
    end else begin
      sync1_q      <= {btn_lap, btn_ss};
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      db_cnt_q[0]  <= db_cnt_d[0];
      db_cnt_q[1]  <= db_cnt_d[1];
      hold_q       <= hold_d;
      long_fired_q <= long_fired_d;
    end
  end

  // FSM next state, lap tracking and registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    lap_act_d = lap_act_q;
    lap_d     = lap_q;

    if (long_c) begin
      state_d   = S_IDLE;
      cnt_clr_d = 1'b1;
      lap_act_d = 1'b0;
      lap_d     = '0;
    end else begin
      if (short_c) begin
        case (state_q)
          S_IDLE:  state_d = S_RUN;
          S_RUN:   state_d = S_PAUSE;
          S_PAUSE: state_d = S_RUN;
          default: state_d = S_IDLE;
        endcase
      end
`ifdef STOPWATCH_AUTO_STOP_EN
      if (state_q == S_RUN && cnt_tc) state_d = S_PAUSE;
`endif
      if (lap_c) begin
        if (state_q == S_RUN) begin
          if (!lap_act_q) begin
            lap_d     = count_in;
            lap_act_d = 1'b1;
          end else begin
            lap_act_d = 1'b0;
          end
        end else if (state_q == S_PAUSE) begin
          lap_act_d = 1'b0;
        end
      end
    end

    cnt_en_d = (state_d == S_RUN);
    disp_d   = lap_act_d ? lap_d : count_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      lap_act_q <= 1'b0;
      lap_q     <= '0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      lap_act_q <= lap_act_d;
      lap_q     <= lap_d;
      disp_q    <= disp_d;
    end
  end

`ifdef STOPWATCH_AUTO_STOP_EN
  logic unused_c;
  assign unused_c = fall_c[1];
`else
  logic unused_c;
  assign unused_c = fall_c[1] ^ cnt_tc;
`endif

  assign cnt_en     = cnt_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign disp_value = disp_q;
  assign lap_active = lap_act_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short debounce/hold thresholds.
module tb_stopwatch_ctrl;

  localparam int unsigned CW = 7;

  logic          clk = 1'b0;
  logic          resetn;
  logic          btn_ss;
  logic          btn_lap;
  logic [CW-1:0] count_in;
  logic          cnt_tc;
  logic          cnt_en;
  logic          cnt_clr;
  logic [CW-1:0] disp_value;
  logic          lap_active;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_fails  = 0;
  int clr_count = 0;
  int clr_base;

  stopwatch_ctrl #(
    .CW(CW),
    .DB_CYCLES(4),
    .LONG_CYCLES(20)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .btn_ss(btn_ss),
    .btn_lap(btn_lap),
    .count_in(count_in),
    .cnt_tc(cnt_tc),
    .cnt_en(cnt_en),
    .cnt_clr(cnt_clr),
    .disp_value(disp_value),
    .lap_active(lap_active),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cnt_clr === 1'b1) clr_count <= clr_count + 1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_ss(input int n);
    btn_ss = 1'b1;
    cyc(n);
    btn_ss = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    btn_ss   = 1'b0;
    btn_lap  = 1'b0;
    count_in = '0;
    cnt_tc   = 1'b0;
    cyc(3);
    resetn = 1'b1;
    cyc(2);

    // Reset state
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
    check("rst_disp", 32'(disp_value), 32'd0);
    check("rst_lap", 32'(lap_active), 32'd0);

    // Short press: IDLE -> RUN within 7 cycles of release
    press_ss(10);
    cyc(7);
    check("short1_state", 32'(state_o), 32'd1);
    check("short1_en", 32'(cnt_en), 32'd1);

    // Second short press: RUN -> PAUSE
    press_ss(10);
    cyc(7);
    check("short2_state", 32'(state_o), 32'd2);
    check("short2_en", 32'(cnt_en), 32'd0);

    // Bouncing button never settles long enough
    for (int i = 0; i < 15; i++) begin
      btn_ss = ~btn_ss;
      cyc(2);
    end
    btn_ss = 1'b0;
    cyc(10);
    check("bounce_state", 32'(state_o), 32'd2);
    check("bounce_en", 32'(cnt_en), 32'd0);

    // Back to RUN
    press_ss(10);
    cyc(7);
    check("run_state", 32'(state_o), 32'd1);

    // Lap capture in RUN
    count_in = 7'd37;
    btn_lap  = 1'b1;
    cyc(8);
    btn_lap  = 1'b0;
    count_in = 7'd45;
    cyc(2);
    check("lap1_active", 32'(lap_active), 32'd1);
    check("lap1_disp", 32'(disp_value), 32'd37);
    cyc(8);

    // Second lap releases the display back to live
    btn_lap = 1'b1;
    cyc(8);
    btn_lap = 1'b0;
    check("lap2_active", 32'(lap_active), 32'd0);
    check("lap2_disp", 32'(disp_value), 32'd45);
    count_in = 7'd50;
    check("lag_before", 32'(disp_value), 32'd45);
    cyc(1);
    check("lag_after", 32'(disp_value), 32'd50);
    cyc(8);

    // Capture 50, then pause with lap frozen
    btn_lap = 1'b1;
    cyc(8);
    btn_lap = 1'b0;
    cyc(8);
    check("lap3_disp", 32'(disp_value), 32'd50);
    press_ss(10);
    cyc(7);
    count_in = 7'd60;
    cyc(2);
    check("pause_state", 32'(state_o), 32'd2);
    check("pause_lap", 32'(lap_active), 32'd1);
    check("pause_disp", 32'(disp_value), 32'd50);

    // Long hold: one clear pulse, back to IDLE
    clr_base = clr_count;
    count_in = 7'd0;
    btn_ss   = 1'b1;
    cyc(30);
    check("long_clr_count", 32'(clr_count - clr_base), 32'd1);
    check("long_state", 32'(state_o), 32'd0);
    check("long_lap", 32'(lap_active), 32'd0);
    check("long_disp", 32'(disp_value), 32'd0);
    check("long_en", 32'(cnt_en), 32'd0);
    btn_ss = 1'b0;
    cyc(12);
    check("long_release_state", 32'(state_o), 32'd0);
    check("long_release_clr", 32'(clr_count - clr_base), 32'd1);

    // Terminal count in RUN
    press_ss(10);
    cyc(7);
    check("tc_pre_state", 32'(state_o), 32'd1);
    cnt_tc = 1'b1;
    cyc(1);
    cnt_tc = 1'b0;
`ifdef STOPWATCH_AUTO_STOP_EN
    check("tc_state", 32'(state_o), 32'd2);
    check("tc_en", 32'(cnt_en), 32'd0);
`else
    check("tc_state", 32'(state_o), 32'd1);
    check("tc_en", 32'(cnt_en), 32'd1);
`endif
    cyc(3);
`ifdef STOPWATCH_AUTO_STOP_EN
    check("tc_hold_state", 32'(state_o), 32'd2);
`else
    check("tc_hold_state", 32'(state_o), 32'd1);
`endif

    // Reset during a held press discards it
    press_ss(10);
    cyc(7);
    btn_ss = 1'b1;
    cyc(10);
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    btn_ss = 1'b0;
    cyc(12);
    check("rst_mid_state", 32'(state_o), 32'd0);
    check("rst_mid_en", 32'(cnt_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
